// File: rtl/afu_line_writer.sv
// afu_line_writer: packs DATA_W result words into LINE_W cache lines, issues one
// write per line to consecutive line addresses and tracks outstanding acks.
module afu_line_writer #(
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_lines,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_almost_full,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       lines_written,
  output logic              err_spurious
);

  localparam int WPL = LINE_W / DATA_W;
  localparam int WIW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam logic [WIW-1:0] LAST_SLOT = WIW'(WPL - 1);
  localparam logic [OW-1:0]  OUT_MAX   = OW'(MAX_OUTST);
  localparam logic [OW-1:0]  OUT_ONE   = OW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       num_lines_q, num_lines_d;
  logic [WIW-1:0]    word_idx_q, word_idx_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              ended_q, ended_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [31:0]       lines_written_q, lines_written_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fire_s;
  logic              accept_s;

  // A write leaves in the same cycle the writer can take it, so the strobe is decoded live.
  assign fire_s   = (state_q == S_ISSUE) && !wr_almost_full && (outst_q < OUT_MAX);
  assign accept_s = in_valid && in_ready_q;

  // Next-state, line assembly and outstanding-write accounting.
  always_comb begin
    state_d         = state_q;
    num_lines_d     = num_lines_q;
    word_idx_d      = word_idx_q;
    line_d          = line_q;
    ended_d         = ended_q;
    wr_addr_d       = wr_addr_q;
    outst_d         = outst_q;
    lines_written_d = lines_written_q;
    err_d           = err_q;

    if (fire_s && !wr_rsp_valid) begin
      outst_d = outst_q + OUT_ONE;
    end else if (!fire_s && wr_rsp_valid) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q - OUT_ONE;
      end
    end else begin
      outst_d = outst_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_lines_d     = num_lines;
          wr_addr_d       = base_addr;
          lines_written_d = 32'd0;
          err_d           = 1'b0;
          word_idx_d      = '0;
          line_d          = '0;
          ended_d         = 1'b0;
          state_d         = (num_lines == 32'd0) ? S_DRAIN : S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s) begin
          line_d[int'(word_idx_q)*DATA_W +: DATA_W] = in_data;
          word_idx_d = word_idx_q + WIW'(1);
          if (in_last || (word_idx_q == LAST_SLOT)) begin
            ended_d = in_last;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_ISSUE: begin
        if (fire_s) begin
          wr_addr_d       = wr_addr_q + ADDR_W'(1);
          lines_written_d = lines_written_q + 32'd1;
          line_d          = '0;
          word_idx_d      = '0;
          if (ended_q || ((lines_written_q + 32'd1) == num_lines_q)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_FILL);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers; reset drops any partial line and in-flight accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      num_lines_q     <= 32'd0;
      word_idx_q      <= '0;
      line_q          <= '0;
      ended_q         <= 1'b0;
      wr_addr_q       <= '0;
      outst_q         <= '0;
      lines_written_q <= 32'd0;
      err_q           <= 1'b0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      num_lines_q     <= num_lines_d;
      word_idx_q      <= word_idx_d;
      line_q          <= line_d;
      ended_q         <= ended_d;
      wr_addr_q       <= wr_addr_d;
      outst_q         <= outst_d;
      lines_written_q <= lines_written_d;
      err_q           <= err_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign wr_valid      = fire_s;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = line_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_written = lines_written_q;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_afu_line_writer.sv
// Directed bench for afu_line_writer: expected writes come from a line-packing
// model fed by the same word stream; directed checks pin timing and flags.
module tb_afu_line_writer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base_addr = 32'd0;
  logic [31:0]  num_lines = 32'd0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = 32'd0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         wr_valid;
  logic [31:0]  wr_addr;
  logic [511:0] wr_data;
  logic         wr_almost_full = 1'b0;
  logic         wr_rsp_valid = 1'b0;
  logic         busy;
  logic         done;
  logic [31:0]  lines_written;
  logic         err_spurious;

  int n_checks = 0;
  int n_fail = 0;
  int writes_seen = 0;
  int done_cnt = 0;
  int model_out = 0;
  logic [31:0]  exp_addr [$];
  logic [511:0] exp_data [$];
  logic [31:0]  log_addr [0:31];
  logic [511:0] log_data [0:31];

  afu_line_writer #(.DATA_W(32), .LINE_W(512), .ADDR_W(32), .MAX_OUTST(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_almost_full(wr_almost_full),
    .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done),
    .lines_written(lines_written), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: cut the word stream v0, v0+1, ... into 16-word lines, zero-padded.
  task automatic expect_lines(input logic [31:0] base, input int nlines, input int nwords,
                              input logic [31:0] v0);
    logic [511:0] d;
    for (int l = 0; l < nlines; l++) begin
      if (l * 16 < nwords) begin
        d = '0;
        for (int k = 0; k < 16; k++)
          if (l * 16 + k < nwords) d[k*32 +: 32] = v0 + 32'(l * 16 + k);
        exp_addr.push_back(base + 32'(l));
        exp_data.push_back(d);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] n);
    tick();
    start = 1'b1; base_addr = base; num_lines = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] v0, input int last_at);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = v0 + 32'(i); in_last = (i == last_at);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: word %0d not accepted, required in_ready=1", i);
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (writes_seen < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (writes_seen < n) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: saw %0d writes, required %0d", writes_seen, n);
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < n) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: saw %0d done pulses, required %0d", done_cnt, n);
    end
  endtask

  task automatic rsp_cycles(input int n);
    wr_rsp_valid = 1'b1;
    repeat (n) tick();
    wr_rsp_valid = 1'b0;
  endtask

  // Per-cycle compare of every write against the model, plus flow-control rules.
  always @(negedge clk) begin
    if (reset) begin
      model_out = 0;
    end else begin
      if (wr_valid) begin
        check("wr_under_almost_full", wr_almost_full, 1'b0);
        check("wr_over_max_outst", 64'(model_out >= 2), 64'd0);
        if (exp_addr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0h, required no write", wr_addr);
        end else begin
          check("wr_addr_model", wr_addr, exp_addr.pop_front());
          n_checks++;
          if (wr_data !== exp_data[0]) begin
            n_fail++;
            $display("FAIL wr_data_model: got %0h expected %0h", wr_data, exp_data[0]);
          end
          void'(exp_data.pop_front());
        end
        if (writes_seen < 32) begin
          log_addr[writes_seen] = wr_addr;
          log_data[writes_seen] = wr_data;
        end
        writes_seen++;
      end
      if (wr_valid && !wr_rsp_valid) model_out++;
      else if (!wr_valid && wr_rsp_valid && model_out > 0) model_out--;
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", 64'(|wr_data), 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lines_written", lines_written, 32'd0);
    check("rst_err", err_spurious, 1'b0);
    reset = 1'b0;
    tick();

    // T1: two full lines, no back-pressure
    expect_lines(32'h100, 2, 32, 32'd0);
    do_start(32'h100, 32'd2);
    send_words(32, 32'd0, -1);
    wait_writes(2);
    repeat (2) tick();
    check("t1_lines_written", lines_written, 32'd2);
    check("t1_busy_drain", busy, 1'b1);
    check("t1_no_done_before_rsp", 64'(done_cnt), 64'd0);
    check("t1_w0_addr", log_addr[0], 32'h100);
    check("t1_w0_word15", log_data[0][511:480], 32'd15);
    check("t1_w1_addr", log_addr[1], 32'h101);
    check("t1_w1_word0", log_data[1][31:0], 32'd16);
    rsp_cycles(2);
    wait_done(1);
    repeat (2) tick();
    check("t1_done_once", 64'(done_cnt), 64'd1);
    check("t1_idle", busy, 1'b0);
    check("t1_err", err_spurious, 1'b0);

    // T2: stream ends early on in_last
    do_start(32'h200, 32'd4);
    check("t2_lw_cleared", lines_written, 32'd0);
    expect_lines(32'h200, 4, 21, 32'h2000_0000);
    send_words(21, 32'h2000_0000, 20);
    wait_writes(4);
    repeat (3) tick();
    check("t2_two_writes", 64'(writes_seen), 64'd4);
    check("t2_in_ready_off", in_ready, 1'b0);
    check("t2_lines_written", lines_written, 32'd2);
    check("t2_w1_word4", log_data[3][159:128], 32'h2000_0014);
    check("t2_w1_word5_zero", log_data[3][191:160], 32'd0);
    rsp_cycles(2);
    wait_done(2);
    repeat (2) tick();
    check("t2_done_once", 64'(done_cnt), 64'd2);

    // T3: writer back-pressure during ISSUE
    wr_almost_full = 1'b1;
    expect_lines(32'h300, 1, 16, 32'h3000_0000);
    do_start(32'h300, 32'd1);
    send_words(16, 32'h3000_0000, -1);
    repeat (10) tick();
    check("t3_held_no_write", 64'(writes_seen), 64'd4);
    wr_almost_full = 1'b0;
    @(negedge clk);
    check("t3_fire_after_drop", wr_valid, 1'b1);
    check("t3_addr_held", wr_addr, 32'h300);
    check("t3_data_held", wr_data[511:480], 32'h3000_000F);
    tick();
    rsp_cycles(1);
    wait_done(3);
    repeat (2) tick();

    // T4: outstanding limit of 2 with responses withheld
    expect_lines(32'h400, 4, 64, 32'h4000_0000);
    do_start(32'h400, 32'd4);
    send_words(48, 32'h4000_0000, -1);
    repeat (5) tick();
    check("t4_stall_at_two", 64'(writes_seen), 64'd7);
    check("t4_lw_two", lines_written, 32'd2);
    check("t4_in_ready_off", in_ready, 1'b0);
    rsp_cycles(2);
    check("t4_third_write", 64'(writes_seen), 64'd8);
    send_words(16, 32'h4000_0030, -1);
    wait_writes(9);
    tick();
    rsp_cycles(1);
    repeat (3) tick();
    check("t4_still_one_outst", 64'(done_cnt), 64'd3);
    check("t4_busy", busy, 1'b1);
    rsp_cycles(1);
    wait_done(4);
    repeat (2) tick();
    check("t4_lines_written", lines_written, 32'd4);
    check("t4_err", err_spurious, 1'b0);

    // T5: empty job, then a spurious response while idle
    do_start(32'h0, 32'd0);
    @(negedge clk);
    check("t5_no_done_early", done, 1'b0);
    check("t5_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    check("t5_done_pulse", done, 1'b1);
    tick();
    check("t5_idle", busy, 1'b0);
    check("t5_no_writes", 64'(writes_seen), 64'd9);
    rsp_cycles(1);
    tick();
    check("t5_err_set", err_spurious, 1'b1);
    repeat (5) tick();
    check("t5_err_sticky", err_spurious, 1'b1);

    // T6: reset mid-fill after one write, then a fresh job
    do_start(32'h500, 32'd3);
    check("t6_err_cleared", err_spurious, 1'b0);
    expect_lines(32'h500, 1, 16, 32'h5000_0000);
    send_words(16, 32'h5000_0000, -1);
    send_words(5, 32'h5000_0010, -1);
    check("t6_one_write", 64'(writes_seen), 64'd10);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_wr_valid", wr_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_lw", lines_written, 32'd0);
    check("t6_rst_wr_data", 64'(|wr_data), 64'd0);
    check("t6_rst_wr_addr", wr_addr, 32'd0);
    reset = 1'b0;
    tick();
    expect_lines(32'h600, 1, 16, 32'h6000_0000);
    do_start(32'h600, 32'd1);
    send_words(16, 32'h6000_0000, -1);
    wait_writes(11);
    tick();
    check("t6_new_base", log_addr[10], 32'h600);
    rsp_cycles(1);
    wait_done(5);
    repeat (2) tick();
    check("t6_lines_written", lines_written, 32'd1);
    check("t6_all_expected_seen", 64'(exp_addr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
